hwpe_kernel_adapter_ctrl: RTL

- Parametrised control/flag generator for HWPE kernel adapters, supporting N_IN sink and N_OUT source streams.
- Observes stream handshakes only; never touches data.
- Counts per-channel transfers against runtime-programmed targets.
- Gates each input once its quota is met, and raises ready/done/idle flags for the engine FSM.
- Instantiated in the kernel adapter alongside the accelerator; the adapter ANDs in_en_o into sink valid and ready.

---
 rtl/hwpe_kernel_adapter_ctrl_if.sv | 18 +
 rtl/hwpe_kernel_adapter_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/hwpe_kernel_adapter_ctrl_if.sv
// Stream handshake bundle between a kernel adapter and its control/flag generator.
// Pure wiring, no latency.
// Control only observes valid/ready; in_en is the per-sink gate driven back to the adapter.
interface hwpe_kernel_adapter_ctrl_if #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1
) ();
  logic [N_IN-1:0]  in_valid;
  logic [N_IN-1:0]  in_ready;
  logic [N_IN-1:0]  in_en;
  logic [N_OUT-1:0] out_valid;
  logic [N_OUT-1:0] out_ready;

  // adapter side: owns the streams, consumes the gate
  modport master (output in_valid, in_ready, out_valid, out_ready, input in_en);
  // control side: watches the streams, produces the gate
  modport slave  (input in_valid, in_ready, out_valid, out_ready, output in_en);
endinterface

// File: rtl/hwpe_kernel_adapter_ctrl.sv
// Counts sink/source beats against programmed targets; gates sinks and flags ready/done/idle.
// done_o one cycle after the last required output beat; idle_o one cycle after that.
// Never stalls streams itself; sinks are gated via in_en once their quota is met.
module hwpe_kernel_adapter_ctrl #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1,
  parameter int CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [N_IN*CNT_W-1:0]  in_max_i,
  input  logic [N_OUT*CNT_W-1:0] out_max_i,
  hwpe_kernel_adapter_ctrl_if.slave hs,
  output logic                   ready_o,
  output logic                   done_o,
  output logic                   beat_o,
  output logic                   idle_o,
  output logic                   ovf_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q  [N_IN];
  logic [CNT_W-1:0] in_cnt_d  [N_IN];
  logic [CNT_W-1:0] out_cnt_q [N_OUT];
  logic [CNT_W-1:0] out_cnt_d [N_OUT];
  logic             ovf_q, ovf_d;
  logic             idle_q, idle_d;
  logic             beat_q, beat_d;

  logic [N_IN-1:0]  in_hs, in_done;
  logic [N_OUT-1:0] out_hs;
  logic             restart, stray, all_out_done;

  assign in_hs  = hs.in_valid & hs.in_ready;
  assign out_hs = hs.out_valid & hs.out_ready;

  // per-sink quota reached, straight from the registered counts
  always_comb begin
    in_done = '0;
    for (int i = 0; i < N_IN; i++) begin
      in_done[i] = (in_cnt_q[i] == in_max_i[i*CNT_W +: CNT_W]);
    end
  end

  assign hs.in_en = (state_q == RUN) ? ~in_done : '0;
  assign ready_o  = (state_q == RUN) & (&in_done);
  assign done_o   = (state_q == DONE);
  assign idle_o   = idle_q;
  assign beat_o   = beat_q;
  assign ovf_o    = ovf_q;

  // next state, saturating counters and sticky overflow; clear overrides everything
  always_comb begin
    state_d      = state_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    restart      = 1'b0;
    stray        = 1'b0;
    all_out_done = 1'b1;
    beat_d       = |out_hs;

    case (state_q)
      IDLE: begin
        stray = |out_hs;
        if (start_i) begin
          restart = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < N_IN; i++) begin
          if (in_hs[i] && (in_cnt_q[i] < in_max_i[i*CNT_W +: CNT_W])) begin
            in_cnt_d[i] = in_cnt_q[i] + CNT_W'(1);
          end
        end
        for (int j = 0; j < N_OUT; j++) begin
          if (out_hs[j]) begin
            if (out_cnt_q[j] < out_max_i[j*CNT_W +: CNT_W]) begin
              out_cnt_d[j] = out_cnt_q[j] + CNT_W'(1);
            end else begin
              stray = 1'b1;
            end
          end
          if (out_cnt_d[j] != out_max_i[j*CNT_W +: CNT_W]) begin
            all_out_done = 1'b0;
          end
        end
        if (all_out_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        stray   = |out_hs;
        restart = start_i;
        state_d = start_i ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (restart) begin
      in_cnt_d  = '{default: '0};
      out_cnt_d = '{default: '0};
    end
    ovf_d = (ovf_q & ~restart) | stray;

    if (clear_i) begin
      state_d   = IDLE;
      in_cnt_d  = '{default: '0};
      out_cnt_d = '{default: '0};
      ovf_d     = 1'b0;
    end

    idle_d = (state_d == IDLE);
  end

  // state and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      in_cnt_q  <= '{default: '0};
      out_cnt_q <= '{default: '0};
      ovf_q     <= 1'b0;
      idle_q    <= 1'b1;
      beat_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      ovf_q     <= ovf_d;
      idle_q    <= idle_d;
      beat_q    <= beat_d;
    end
  end

endmodule
